ins_dispatch_buf: RTL
=====================

Name: ins_dispatch_buf

Overview:
- Parametrised instruction dispatch stage between fetch and decode.
- Accepts raw 32-bit RV32 instructions with their PC over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Splits each instruction into register indices, funct fields and one format-selected, sign-extended immediate, held in a registered output slot.
- Generalises the fixed field-dispatch bundle: adds XLEN and register-index width, buffering, back-pressure, flush, format tagging and illegal-encoding detection.

Parameters:
XLEN, 32, datapath width for the immediate and PC; must be ≥ 32.
REG_AW, 4, register index width; 4 = RV32E (16 registers), 5 = RV32I (32 registers).
DEPTH, 4, FIFO entries (power of two, ≥ 2); total capacity is DEPTH+1 including the output slot.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
flush  input  1  discard all buffered and output-slot instructions.
in_vld  input  1  in_ins and in_pc are valid.
in_rdy  output  1  block can accept an instruction this cycle.
in_ins  input  32  raw instruction word.
in_pc  input  XLEN  PC of in_ins.
out_vld  output  1  output slot holds a decoded instruction.
out_rdy  input  1  downstream consumes the output slot this cycle.
out_pc  output  XLEN  PC of the output instruction.
out_op  output  7  ins[6:0].
out_funct3  output  3  ins[14:12].
out_funct7  output  7  ins[31:25].
out_rd  output  REG_AW  ins[7+REG_AW-1:7].
out_rs1  output  REG_AW  ins[15+REG_AW-1:15].
out_rs2  output  REG_AW  ins[20+REG_AW-1:20].
out_shamt  output  5  ins[24:20].
out_imm  output  XLEN  immediate selected by format, sign-extended to XLEN.
out_fmt  output  3  InsFmt code: R, I, S, B, U, J or NONE.
out_illegal  output  1  unknown opcode, or register index out of range for REG_AW.
occupancy  output  $clog2(DEPTH+2)  FIFO count plus output-slot valid.

Behaviour:
- Reset, sampled on clk:
  - FIFO is emptied; out_vld = 0.
  - All out_* data outputs = 0; out_fmt = NONE.
  - occupancy = 0; in_rdy = 1 in the cycle after reset deasserts.
- Handshakes:
  - Accept when in_vld & in_rdy. Pop when out_vld & out_rdy.
  - in_rdy = (fifo_count < DEPTH) & !flush.
- Output slot stability: while out_vld & !out_rdy, every out_* output holds stable.
- Latency, bypass case: if the FIFO is empty and the slot is empty or popping, an accepted instruction loads directly into the slot. out_vld rises the next cycle (1-cycle latency).
- Latency, buffered case:
  - Otherwise the accepted instruction is written to the FIFO tail.
  - The slot reloads from the FIFO head whenever the slot is empty or popping and the FIFO is non-empty. FIFO order always takes priority over the bypass path.
- Full FIFO: in_rdy is low even if a pop occurs in the same cycle (no combinational full bypass). The FIFO pointers wrap modulo DEPTH.
- Flush has priority over all other events:
  - Next cycle: FIFO empty, out_vld = 0, occupancy = 0.
  - A pop in the flush cycle still completes downstream.
  - in_rdy = 0 during flush, so no instruction is accepted.
- Reset asserted mid-operation behaves exactly like reset from idle, i.e. it is a superset of flush.
- Format decode on ins[6:0], evaluated when the slot loads:
  - 0110011 → R.
  - 0010011, 0000011, 1100111, 1110011 → I.
  - 0100011 → S.
  - 1100011 → B.
  - 0110111, 0010111 → U.
  - 1101111 → J.
  - Any other opcode → NONE, with out_illegal = 1 and out_imm = 0.
- Immediates (all sign-extended from ins[31] to XLEN):
  - I: ins[31:20].
  - S: {ins[31:25], ins[11:7]}.
  - B: {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}.
  - U: {ins[31:12], 12'b0}.
  - J: {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}.
  - R: out_imm = 0.
- Register range check:
  - With REG_AW = 4, out_illegal = 1 when any used field (by format) has its bit 4 set: ins[11] for rd, ins[19] for rs1, ins[24] for rs2.
  - Indices are truncated to REG_AW bits regardless.
- Illegal instructions are still dispatched normally; downstream raises the exception.

Decomposition:
- Shared package (ZionDataType):
  - InsFmt enum (R, I, S, B, U, J, NONE).
  - Opcode constants OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG, OP_SYSTEM.
  - A parametrised DispatchPkt struct type: fields, immediate, fmt, illegal, pc.
- Sub-module ins_field_decode: combinational raw ins → DispatchPkt, instantiated once on the slot load path.
- The FIFO and slot control stay in ins_dispatch_buf.

Test Plan:
1. Reset, then push ADDI x5,x1,-1 (0xFFF08293) at PC 0x100 → next cycle: out_vld = 1, fmt = I, imm = 0xFFFFFFFF, rd = 5, rs1 = 1, illegal = 0, pc = 0x100.
2. Hold out_rdy = 0 and push 5 instructions (DEPTH = 4) → in_rdy falls after the 5th accept and occupancy = 5. Release out_rdy → all 5 emerge in order with stable outputs while stalled.
3. Decode BEQ 0x00208463 (imm = 8) and JAL 0x8000006F (imm = 0xFFF00000) → fmt B and J with the stated values; SW 0xFE112E23 → fmt S, imm = 0xFFFFFFFC.
4. REG_AW = 4: push ADD x16,x1,x2 (0x00208833) → illegal = 1, rd = 0. Opcode 0x0000007F → fmt NONE, illegal = 1, imm = 0.
5. With 3 buffered, assert flush together with in_vld → next cycle out_vld = 0, occupancy = 0, and the flush-cycle input is not accepted.
6. Continuous push/pop at full rate with out_rdy = 1 for 1000 random instructions → throughput of 1 per cycle, no loss or duplication, order preserved across pointer wrap.

Source files
------------

// File: rtl/ins_dispatch_buf_pkg.sv
// Shared types for the instruction dispatch buffer: format codes, RV32 opcodes
// and the packet width helper used to pass decoded packets between modules.
package ins_dispatch_buf_pkg;

   typedef enum logic [2:0] {
      FMT_R    = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5,
      FMT_NONE = 3'd7
   } ins_fmt_e;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   // Width of the flattened DispatchPkt: pc, imm, op, funct3, funct7, rd/rs1/rs2, shamt, fmt, illegal.
   function automatic int dispatch_pkt_w(input int xlen, input int reg_aw);
      return 2 * xlen + 7 + 3 + 7 + 3 * reg_aw + 5 + 3 + 1;
   endfunction

   function automatic ins_fmt_e op_fmt(input logic [6:0] op);
      case (op)
         OP_REG:                             return FMT_R;
         OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: return FMT_I;
         OP_STORE:                           return FMT_S;
         OP_BRANCH:                          return FMT_B;
         OP_LUI, OP_AUIPC:                   return FMT_U;
         OP_JAL:                             return FMT_J;
         default:                            return FMT_NONE;
      endcase
   endfunction

endpackage

// File: rtl/ins_dispatch_buf_decode.sv
// Combinational field splitter: raw RV32 word plus PC into a flattened DispatchPkt
// with format tag, sign-extended immediate and illegal-encoding flag.
module ins_field_decode
   import ins_dispatch_buf_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int REG_AW = 4
) (
   input  logic [31:0]                              i_ins,
   input  logic [XLEN-1:0]                          i_pc,
   output logic [dispatch_pkt_w(XLEN, REG_AW)-1:0]  o_pkt
);

   typedef struct packed {
      logic [XLEN-1:0]   pc;
      logic [XLEN-1:0]   imm;
      logic [6:0]        op;
      logic [2:0]        funct3;
      logic [6:0]        funct7;
      logic [REG_AW-1:0] rd;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic [4:0]        shamt;
      ins_fmt_e          fmt;
      logic              illegal;
   } dispatch_pkt_t;

   dispatch_pkt_t      w_pkt;
   ins_fmt_e           w_fmt;
   logic signed [31:0] w_imm32;
   logic               w_use_rd, w_use_rs1, w_use_rs2;
   logic               w_rd_hi, w_rs1_hi, w_rs2_hi;

   always_comb begin
      w_fmt = op_fmt(i_ins[6:0]);
      w_imm32 = '0;
      case (w_fmt)
         FMT_I:   w_imm32 = {{20{i_ins[31]}}, i_ins[31:20]};
         FMT_S:   w_imm32 = {{20{i_ins[31]}}, i_ins[31:25], i_ins[11:7]};
         FMT_B:   w_imm32 = {{19{i_ins[31]}}, i_ins[31], i_ins[7], i_ins[30:25], i_ins[11:8], 1'b0};
         FMT_U:   w_imm32 = {i_ins[31:12], 12'b0};
         FMT_J:   w_imm32 = {{11{i_ins[31]}}, i_ins[31], i_ins[19:12], i_ins[20], i_ins[30:21], 1'b0};
         default: w_imm32 = '0;
      endcase

      w_use_rd  = (w_fmt == FMT_R) || (w_fmt == FMT_I) || (w_fmt == FMT_U) || (w_fmt == FMT_J);
      w_use_rs1 = (w_fmt == FMT_R) || (w_fmt == FMT_I) || (w_fmt == FMT_S) || (w_fmt == FMT_B);
      w_use_rs2 = (w_fmt == FMT_R) || (w_fmt == FMT_S) || (w_fmt == FMT_B);

      // Any 5-bit index bit at or above REG_AW names a register this core lacks.
      w_rd_hi  = |(i_ins[11:7]  >> REG_AW);
      w_rs1_hi = |(i_ins[19:15] >> REG_AW);
      w_rs2_hi = |(i_ins[24:20] >> REG_AW);

      w_pkt.pc      = i_pc;
      w_pkt.imm     = XLEN'(w_imm32);
      w_pkt.op      = i_ins[6:0];
      w_pkt.funct3  = i_ins[14:12];
      w_pkt.funct7  = i_ins[31:25];
      w_pkt.rd      = i_ins[7 +: REG_AW];
      w_pkt.rs1     = i_ins[15 +: REG_AW];
      w_pkt.rs2     = i_ins[20 +: REG_AW];
      w_pkt.shamt   = i_ins[24:20];
      w_pkt.fmt     = w_fmt;
      w_pkt.illegal = (w_fmt == FMT_NONE) || (w_use_rd && w_rd_hi)
                      || (w_use_rs1 && w_rs1_hi) || (w_use_rs2 && w_rs2_hi);
   end

   assign o_pkt = w_pkt;

endmodule

// File: rtl/ins_dispatch_buf.sv
// Fetch-to-decode dispatch stage: DEPTH-entry raw-instruction FIFO feeding one
// registered decoded output slot, with bypass when the FIFO is empty and flush.
module ins_dispatch_buf
   import ins_dispatch_buf_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int REG_AW = 4,
   parameter int DEPTH  = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         in_vld,
   output logic                         in_rdy,
   input  logic [31:0]                  in_ins,
   input  logic [XLEN-1:0]              in_pc,
   output logic                         out_vld,
   input  logic                         out_rdy,
   output logic [XLEN-1:0]              out_pc,
   output logic [6:0]                   out_op,
   output logic [2:0]                   out_funct3,
   output logic [6:0]                   out_funct7,
   output logic [REG_AW-1:0]            out_rd,
   output logic [REG_AW-1:0]            out_rs1,
   output logic [REG_AW-1:0]            out_rs2,
   output logic [4:0]                   out_shamt,
   output logic [XLEN-1:0]              out_imm,
   output logic [2:0]                   out_fmt,
   output logic                         out_illegal,
   output logic [$clog2(DEPTH+2)-1:0]   occupancy
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int OCC_W = $clog2(DEPTH + 2);

   typedef struct packed {
      logic [XLEN-1:0]   pc;
      logic [XLEN-1:0]   imm;
      logic [6:0]        op;
      logic [2:0]        funct3;
      logic [6:0]        funct7;
      logic [REG_AW-1:0] rd;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic [4:0]        shamt;
      ins_fmt_e          fmt;
      logic              illegal;
   } dispatch_pkt_t;

   logic [31:0]       r_mem_ins [DEPTH];
   logic [XLEN-1:0]   r_mem_pc  [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic              r_out_vld;
   dispatch_pkt_t     r_pkt;

   logic              w_accept, w_pop, w_slot_free, w_fifo_empty;
   logic              w_fifo_rd, w_fifo_wr, w_bypass;
   logic [31:0]       w_src_ins;
   logic [XLEN-1:0]   w_src_pc;
   logic [dispatch_pkt_w(XLEN, REG_AW)-1:0] w_dec_flat;
   dispatch_pkt_t     w_dec;

   // Handshake: a transfer happens on a cycle where valid and ready are both high;
   // in_rdy never depends on in_vld, and out_* hold while out_vld is high and out_rdy low.
   assign in_rdy       = (r_count < CNT_W'(DEPTH)) && !flush;
   assign w_accept     = in_vld && in_rdy;
   assign w_pop        = r_out_vld && out_rdy;
   assign w_slot_free  = !r_out_vld || out_rdy;
   assign w_fifo_empty = (r_count == '0);
   assign w_fifo_rd    = w_slot_free && !w_fifo_empty;
   assign w_bypass     = w_slot_free && w_fifo_empty && w_accept;
   assign w_fifo_wr    = w_accept && !w_bypass;

   // Buffered entries are older than the input, so the head wins the slot.
   assign w_src_ins = w_fifo_empty ? in_ins : r_mem_ins[r_rd_ptr];
   assign w_src_pc  = w_fifo_empty ? in_pc  : r_mem_pc[r_rd_ptr];

   ins_field_decode #(.XLEN(XLEN), .REG_AW(REG_AW)) u_decode (
      .i_ins (w_src_ins),
      .i_pc  (w_src_pc),
      .o_pkt (w_dec_flat)
   );
   assign w_dec = w_dec_flat;

   always_ff @(posedge clk) begin
      if (w_fifo_wr) begin
         r_mem_ins[r_wr_ptr] <= in_ins;
         r_mem_pc[r_wr_ptr]  <= in_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_fifo_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_fifo_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= r_count + CNT_W'(w_fifo_wr) - CNT_W'(w_fifo_rd);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_vld <= 1'b0;
         r_pkt     <= '0;
         r_pkt.fmt <= FMT_NONE;
      end else if (flush) begin
         r_out_vld <= 1'b0;
      end else if (w_fifo_rd || w_bypass) begin
         r_out_vld <= 1'b1;
         r_pkt     <= w_dec;
      end else if (w_pop) begin
         r_out_vld <= 1'b0;
      end
   end

   assign out_vld     = r_out_vld;
   assign out_pc      = r_pkt.pc;
   assign out_op      = r_pkt.op;
   assign out_funct3  = r_pkt.funct3;
   assign out_funct7  = r_pkt.funct7;
   assign out_rd      = r_pkt.rd;
   assign out_rs1     = r_pkt.rs1;
   assign out_rs2     = r_pkt.rs2;
   assign out_shamt   = r_pkt.shamt;
   assign out_imm     = r_pkt.imm;
   assign out_fmt     = r_pkt.fmt;
   assign out_illegal = r_pkt.illegal;
   assign occupancy   = OCC_W'(r_count) + OCC_W'(r_out_vld);

endmodule
